ahb_async_sram_ctrl: RTL

//  AHB-Lite slave bridging a 32-bit bus to an external 16-bit asynchronous SRAM
//  (e.g. 256Kx16). Sits directly downstream of the write-back cache's master

---
 rtl/ahb_async_sram_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_async_sram_ctrl.sv
// AHB-Lite slave to 16-bit asynchronous SRAM bridge.
// Words take two SRAM beats (low half first); bytes and halfwords take one.
module ahb_async_sram_ctrl #(
    parameter int W_SRAM_ADDR = 18,
    parameter int RD_CYCLES   = 2,
    parameter int WR_CYCLES   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ahbls_hready_resp,
    input  logic                   ahbls_hready,
    output logic                   ahbls_hresp,
    input  logic [31:0]            ahbls_haddr,
    input  logic                   ahbls_hwrite,
    input  logic [1:0]             ahbls_htrans,
    input  logic [2:0]             ahbls_hsize,
    input  logic [31:0]            ahbls_hwdata,
    output logic [31:0]            ahbls_hrdata,
    output logic [W_SRAM_ADDR-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_ce_n,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic [1:0]             sram_byte_n
);

    localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYCLES - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WR_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_STROBE,
        S_WR_SETUP,
        S_WR_STROBE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   beat_q, beat_d;
    logic                   word_q, word_d;
    logic                   write_q, write_d;
    logic [W_SRAM_ADDR-2:0] row_q, row_d;
    logic                   hi_sel_q, hi_sel_d;
    logic                   hready_resp_q, hready_resp_d;
    logic [31:0]            hrdata_q, hrdata_d;
    logic [W_SRAM_ADDR-1:0] addr_q, addr_d;
    logic [15:0]            dq_out_q, dq_out_d;
    logic                   dq_oe_q, dq_oe_d;
    logic                   ce_n_q, ce_n_d;
    logic                   we_n_q, we_n_d;
    logic                   oe_n_q, oe_n_d;
    logic [1:0]             byte_n_q, byte_n_d;

    logic       accept;
    logic       req_word;
    logic [1:0] req_byte_n;
    logic       unused_ahb;

    assign unused_ahb = ^{ahbls_htrans[0], ahbls_haddr[31:W_SRAM_ADDR+1]};

    assign accept   = ahbls_hready && ahbls_htrans[1] && hready_resp_q;
    assign req_word = (ahbls_hsize >= 3'd2);

    // Only a byte access narrows the lane strobes; haddr[0] picks ub/lb.
    always_comb begin
        req_byte_n = 2'b00;
        if (ahbls_hsize == 3'd0) begin
            req_byte_n = ahbls_haddr[0] ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        beat_d        = beat_q;
        word_d        = word_q;
        write_d       = write_q;
        row_d         = row_q;
        hi_sel_d      = hi_sel_q;
        hready_resp_d = 1'b0;
        hrdata_d      = hrdata_q;
        addr_d        = addr_q;
        dq_out_d      = dq_out_q;
        dq_oe_d       = 1'b0;
        ce_n_d        = 1'b1;
        we_n_d        = 1'b1;
        oe_n_d        = 1'b1;
        byte_n_d      = 2'b11;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    word_d   = req_word;
                    write_d  = ahbls_hwrite;
                    row_d    = ahbls_haddr[W_SRAM_ADDR:2];
                    hi_sel_d = ahbls_haddr[1];
                    beat_d   = 1'b0;
                    addr_d   = req_word ? {ahbls_haddr[W_SRAM_ADDR:2], 1'b0}
                                        : ahbls_haddr[W_SRAM_ADDR:1];
                    byte_n_d = req_byte_n;
                    ce_n_d   = 1'b0;
                    if (ahbls_hwrite) begin
                        state_d = S_WR_SETUP;
                    end else begin
                        state_d = S_RD_STROBE;
                        oe_n_d  = 1'b0;
                        cnt_d   = RD_LOAD;
                    end
                end else begin
                    state_d       = S_IDLE;
                    hready_resp_d = 1'b1;
                end
            end

            S_RD_STROBE: begin
                ce_n_d   = 1'b0;
                oe_n_d   = 1'b0;
                byte_n_d = byte_n_q;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (word_q && !beat_q) begin
                    hrdata_d[15:0] = sram_dq_in;
                    beat_d         = 1'b1;
                    addr_d         = {row_q, 1'b1};
                    cnt_d          = RD_LOAD;
                end else begin
                    // A single-beat read is replicated so either lane is valid.
                    hrdata_d      = word_q ? {sram_dq_in, hrdata_q[15:0]}
                                           : {sram_dq_in, sram_dq_in};
                    state_d       = S_DONE;
                    ce_n_d        = 1'b1;
                    oe_n_d        = 1'b1;
                    byte_n_d      = 2'b11;
                    hready_resp_d = 1'b1;
                end
            end

            S_WR_SETUP: begin
                state_d  = S_WR_STROBE;
                cnt_d    = WR_LOAD;
                ce_n_d   = 1'b0;
                we_n_d   = 1'b0;
                dq_oe_d  = 1'b1;
                byte_n_d = byte_n_q;
                dq_out_d = (word_q ? beat_q : hi_sel_q) ? ahbls_hwdata[31:16]
                                                        : ahbls_hwdata[15:0];
            end

            S_WR_STROBE: begin
                ce_n_d   = 1'b0;
                dq_oe_d  = 1'b1;
                byte_n_d = byte_n_q;
                if (cnt_q != '0) begin
                    cnt_d  = cnt_q - CNT_ONE;
                    we_n_d = 1'b0;
                end else if (word_q && !beat_q) begin
                    beat_d  = 1'b1;
                    addr_d  = {row_q, 1'b1};
                    state_d = S_WR_SETUP;
                end else begin
                    // dq stays driven through DONE as data hold after we_n rises.
                    state_d       = S_DONE;
                    ce_n_d        = 1'b1;
                    byte_n_d      = 2'b11;
                    hready_resp_d = 1'b1;
                end
            end

            default: begin
                state_d       = S_IDLE;
                hready_resp_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            beat_q        <= 1'b0;
            word_q        <= 1'b0;
            write_q       <= 1'b0;
            row_q         <= '0;
            hi_sel_q      <= 1'b0;
            hready_resp_q <= 1'b1;
            hrdata_q      <= '0;
            addr_q        <= '0;
            dq_out_q      <= '0;
            dq_oe_q       <= 1'b0;
            ce_n_q        <= 1'b1;
            we_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            byte_n_q      <= 2'b11;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            beat_q        <= beat_d;
            word_q        <= word_d;
            write_q       <= write_d;
            row_q         <= row_d;
            hi_sel_q      <= hi_sel_d;
            hready_resp_q <= hready_resp_d;
            hrdata_q      <= hrdata_d;
            addr_q        <= addr_d;
            dq_out_q      <= dq_out_d;
            dq_oe_q       <= dq_oe_d;
            ce_n_q        <= ce_n_d;
            we_n_q        <= we_n_d;
            oe_n_q        <= oe_n_d;
            byte_n_q      <= byte_n_d;
        end
    end

    logic unused_write;
    assign unused_write = write_q;

    assign ahbls_hready_resp = hready_resp_q;
    assign ahbls_hresp       = 1'b0;
    assign ahbls_hrdata      = hrdata_q;
    assign sram_addr         = addr_q;
    assign sram_dq_out       = dq_out_q;
    assign sram_dq_oe        = dq_oe_q;
    assign sram_ce_n         = ce_n_q;
    assign sram_we_n         = we_n_q;
    assign sram_oe_n         = oe_n_q;
    assign sram_byte_n       = byte_n_q;

endmodule
